// File: rtl/conv_tile_scheduler.sv
// Walks an odd-sized image in 3x3 windows at stride 2, driving the 2x2 conv core
// and streaming its four results into result RAM. Configured over Avalon-MM.
module conv_tile_scheduler #(
    parameter int DIM_W          = 16,
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              csi_clockreset_clk,
    input  logic              csi_clockreset_reset_n,
    input  logic [3:0]        avs_s1_address,
    input  logic              avs_s1_read,
    input  logic              avs_s1_write,
    input  logic [31:0]       avs_s1_writedata,
    output logic [31:0]       avs_s1_readdata,
    output logic              img_rd,
    output logic [ADDR_W-1:0] img_addr,
    input  logic [31:0]       img_rdata,
    output logic              res_wr,
    output logic [ADDR_W-1:0] res_addr,
    output logic [31:0]       res_wdata,
    output logic              core_start,
    output logic [31:0]       core_in_0,
    output logic [31:0]       core_in_1,
    output logic [31:0]       core_in_2,
    output logic [31:0]       core_in_3,
    output logic [31:0]       core_in_4,
    output logic [31:0]       core_in_5,
    output logic [31:0]       core_in_6,
    output logic [31:0]       core_in_7,
    output logic [31:0]       core_in_8,
    input  logic              core_done,
    input  logic [31:0]       core_out_0,
    input  logic [31:0]       core_out_1,
    input  logic [31:0]       core_out_2,
    input  logic [31:0]       core_out_3
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_START, S_WAIT, S_WRITE, S_ADV
    } state_t;

    state_t            r_state, w_next;
    logic [DIM_W-1:0]  r_img_w, r_img_h, r_r, r_c;
    logic [ADDR_W-1:0] r_src, r_dst, r_src_row, r_dst_row, r_row;
    logic [31:0]       r_tile_cnt;
    logic              r_done, r_err_cfg, r_err_to, r_aborted;
    logic [3:0]        r_k;
    logic [1:0]        r_kc, r_j;
    logic [TW-1:0]     r_wait;
    logic [31:0]       r_in [9];
    logic [31:0]       r_out [4];

    logic              w_busy, w_go, w_abort, w_cfg_bad, w_reg_we;
    logic              w_last_col, w_last_row, w_timeout, w_unused;
    logic [ADDR_W-1:0] w_wa, w_wm1, w_ca, w_nsrc_row, w_ndst_row;

    assign w_busy    = (r_state != S_IDLE);
    assign w_abort   = avs_s1_write && avs_s1_address == 4'd0 && avs_s1_writedata[1];
    assign w_go      = avs_s1_write && avs_s1_address == 4'd0 && avs_s1_writedata[0] && !w_abort;
    assign w_reg_we  = avs_s1_write && !w_busy;
    assign w_cfg_bad = (r_img_w < DIM_W'(3)) || (r_img_h < DIM_W'(3)) || !r_img_w[0] || !r_img_h[0];
    assign w_last_col = ({1'b0, r_c} + (DIM_W+1)'(4)) >= {1'b0, r_img_w};
    assign w_last_row = ({1'b0, r_r} + (DIM_W+1)'(4)) >= {1'b0, r_img_h};
    assign w_timeout = !core_done && (r_wait == TW'(TIMEOUT_CYCLES - 1));
    assign w_unused  = ^{avs_s1_read, avs_s1_writedata};

    // Row bases advance by W (image) or W-1 (result) instead of multiplying.
    assign w_wa       = ADDR_W'(r_img_w);
    assign w_wm1      = w_wa - ADDR_W'(1);
    assign w_ca       = ADDR_W'(r_c);
    assign w_nsrc_row = r_src_row + w_wa + w_wa;
    assign w_ndst_row = r_dst_row + w_wm1 + w_wm1;

    assign img_addr  = r_row + w_ca + ADDR_W'(r_kc);
    assign res_addr  = r_row + w_ca + ADDR_W'(r_j[0]);
    assign res_wdata = r_out[r_j];
    assign core_in_0 = r_in[0];
    assign core_in_1 = r_in[1];
    assign core_in_2 = r_in[2];
    assign core_in_3 = r_in[3];
    assign core_in_4 = r_in[4];
    assign core_in_5 = r_in[5];
    assign core_in_6 = r_in[6];
    assign core_in_7 = r_in[7];
    assign core_in_8 = r_in[8];

    always_comb begin
        w_next     = r_state;
        img_rd     = 1'b0;
        res_wr     = 1'b0;
        core_start = 1'b0;
        unique case (r_state)
            S_IDLE:  if (w_go && !w_cfg_bad) w_next = S_FETCH;
            S_FETCH: begin
                img_rd = (r_k != 4'd9);
                if (r_k == 4'd9) w_next = S_START;
            end
            S_START: begin
                core_start = 1'b1;
                w_next     = S_WAIT;
            end
            S_WAIT: begin
                if (core_done)      w_next = S_WRITE;
                else if (w_timeout) w_next = S_IDLE;
            end
            S_WRITE: begin
                res_wr = 1'b1;
                if (r_j == 2'd3) w_next = S_ADV;
            end
            S_ADV:   w_next = (w_last_col && w_last_row) ? S_IDLE : S_FETCH;
            default: w_next = S_IDLE;
        endcase
        if (w_abort && w_busy) w_next = S_IDLE;
    end

    always_comb begin
        avs_s1_readdata = '0;
        case (avs_s1_address)
            4'd1: avs_s1_readdata = {27'd0, r_aborted, r_err_to, r_err_cfg, r_done, w_busy};
            4'd2: avs_s1_readdata = 32'(r_img_w);
            4'd3: avs_s1_readdata = 32'(r_img_h);
            4'd4: avs_s1_readdata = 32'(r_src);
            4'd5: avs_s1_readdata = 32'(r_dst);
            4'd6: avs_s1_readdata = r_tile_cnt;
            default: avs_s1_readdata = '0;
        endcase
    end

    always_ff @(posedge csi_clockreset_clk) begin
        if (!csi_clockreset_reset_n) begin
            r_state <= S_IDLE;
            r_img_w <= '0;  r_img_h <= '0;  r_r <= '0;  r_c <= '0;
            r_src <= '0;  r_dst <= '0;  r_src_row <= '0;  r_dst_row <= '0;
            r_row <= '0;  r_tile_cnt <= '0;  r_k <= '0;  r_kc <= '0;
            r_j <= '0;  r_wait <= '0;
            r_done <= 1'b0;  r_err_cfg <= 1'b0;
            r_err_to <= 1'b0;  r_aborted <= 1'b0;
            for (int i = 0; i < 9; i++) r_in[i] <= '0;
            for (int i = 0; i < 4; i++) r_out[i] <= '0;
        end else begin
            r_state <= w_next;
            if (w_reg_we) begin
                case (avs_s1_address)
                    4'd2: r_img_w <= avs_s1_writedata[DIM_W-1:0];
                    4'd3: r_img_h <= avs_s1_writedata[DIM_W-1:0];
                    4'd4: r_src   <= avs_s1_writedata[ADDR_W-1:0];
                    4'd5: r_dst   <= avs_s1_writedata[ADDR_W-1:0];
                    default: ;
                endcase
            end
            if (avs_s1_write && avs_s1_address == 4'd1) begin
                if (avs_s1_writedata[1]) r_done    <= 1'b0;
                if (avs_s1_writedata[2]) r_err_cfg <= 1'b0;
                if (avs_s1_writedata[3]) r_err_to  <= 1'b0;
                if (avs_s1_writedata[4]) r_aborted <= 1'b0;
            end
            unique case (r_state)
                S_IDLE: if (w_go) begin
                    if (w_cfg_bad) begin
                        r_err_cfg <= 1'b1;
                    end else begin
                        r_tile_cnt <= '0;
                        r_done <= 1'b0;  r_err_cfg <= 1'b0;
                        r_err_to <= 1'b0;  r_aborted <= 1'b0;
                        r_r <= '0;  r_c <= '0;  r_k <= '0;  r_kc <= '0;
                        r_src_row <= r_src;
                        r_dst_row <= r_dst;
                        r_row     <= r_src;
                    end
                end
                S_FETCH: begin
                    if (r_k != 4'd0) r_in[r_k - 4'd1] <= img_rdata;
                    if (r_k == 4'd9) begin
                        r_k <= '0;
                    end else begin
                        r_k <= r_k + 4'd1;
                        if (r_kc == 2'd2) begin
                            r_kc  <= '0;
                            r_row <= r_row + w_wa;
                        end else begin
                            r_kc <= r_kc + 2'd1;
                        end
                    end
                end
                S_START: r_wait <= '0;
                S_WAIT: begin
                    if (core_done) begin
                        r_out[0] <= core_out_0;
                        r_out[1] <= core_out_1;
                        r_out[2] <= core_out_2;
                        r_out[3] <= core_out_3;
                        r_row    <= r_dst_row;
                        r_j      <= '0;
                    end else begin
                        r_wait <= r_wait + TW'(1);
                        if (w_timeout) r_err_to <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_j <= r_j + 2'd1;
                    if (r_j == 2'd1) r_row <= r_row + w_wm1;
                end
                S_ADV: begin
                    r_tile_cnt <= r_tile_cnt + 32'd1;
                    if (w_last_col) begin
                        r_c       <= '0;
                        r_r       <= r_r + DIM_W'(2);
                        r_src_row <= w_nsrc_row;
                        r_dst_row <= w_ndst_row;
                        r_row     <= w_nsrc_row;
                        if (w_last_row && !w_abort) r_done <= 1'b1;
                    end else begin
                        r_c   <= r_c + DIM_W'(2);
                        r_row <= r_src_row;
                    end
                end
                default: ;
            endcase
            if (w_abort && w_busy) r_aborted <= 1'b1;
        end
    end
endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Bench for conv_tile_scheduler: RAM and core models, window-walk reference model,
// directed error/abort/reset cases and randomized image configurations.
module tb_conv_tile_scheduler;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  av_addr;
    logic        av_rd, av_wr;
    logic [31:0] av_wd, av_rdata;
    logic        img_rd, res_wr, core_start, core_done;
    logic [15:0] img_addr, res_addr;
    logic [31:0] img_rdata, res_wdata;
    logic [31:0] cin [9];
    logic [31:0] cout [4];

    always #5 clk = ~clk;

    conv_tile_scheduler dut (
        .csi_clockreset_clk(clk), .csi_clockreset_reset_n(rst_n),
        .avs_s1_address(av_addr), .avs_s1_read(av_rd), .avs_s1_write(av_wr),
        .avs_s1_writedata(av_wd), .avs_s1_readdata(av_rdata),
        .img_rd(img_rd), .img_addr(img_addr), .img_rdata(img_rdata),
        .res_wr(res_wr), .res_addr(res_addr), .res_wdata(res_wdata),
        .core_start(core_start),
        .core_in_0(cin[0]), .core_in_1(cin[1]), .core_in_2(cin[2]),
        .core_in_3(cin[3]), .core_in_4(cin[4]), .core_in_5(cin[5]),
        .core_in_6(cin[6]), .core_in_7(cin[7]), .core_in_8(cin[8]),
        .core_done(core_done),
        .core_out_0(cout[0]), .core_out_1(cout[1]),
        .core_out_2(cout[2]), .core_out_3(cout[3])
    );

    int          n_chk = 0, n_pass = 0;
    logic [31:0] mem [0:65535];
    logic [15:0] rd_q [$];
    logic [47:0] wr_q [$];
    logic [31:0] last_cin [9];
    int          n_starts = 0, d_sum = 0, d_fixed = 0, hang_from = 1000;
    int          overlap = 0, rem = 0;
    logic        pend = 1'b0;
    logic [15:0] pend_a = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Image RAM (1-cycle read latency), result capture and conv core model.
    initial begin
        img_rdata = '0;
        core_done = 1'b0;
        for (int j = 0; j < 4; j++) cout[j] = '0;
        forever begin
            @(negedge clk);
            img_rdata = pend ? mem[pend_a] : $urandom;
            pend   = img_rd;
            pend_a = img_addr;
            if (img_rd) rd_q.push_back(img_addr);
            if (res_wr) wr_q.push_back({res_addr, res_wdata});
            if (img_rd && res_wr) overlap++;
            if (core_start) begin
                n_starts++;
                for (int k = 0; k < 9; k++) last_cin[k] = cin[k];
                if (n_starts >= hang_from) rem = 0;
                else begin
                    rem = (d_fixed != 0) ? d_fixed : int'($urandom_range(1, 4));
                    d_sum += rem;
                end
                core_done = 1'b0;
            end else if (rem > 0) begin
                rem--;
                core_done = (rem == 0);
            end else begin
                core_done = 1'b0;
            end
            for (int j = 0; j < 4; j++)
                cout[j] = cin[(j / 2) * 3 + j % 2] + 32'h100 * (j + 1);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        av_addr = a; av_wd = d; av_wr = 1'b1;
        @(negedge clk);
        av_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        av_addr = a; av_rd = 1'b1;
        #1 d = av_rdata;
        av_rd = 1'b0;
    endtask

    task automatic go_and_wait(output int cyc);
        @(negedge clk);
        av_addr = 4'd0; av_wd = 32'd1; av_wr = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        av_wr = 1'b0; av_addr = 4'd1;
        #1;
        while (av_rdata[0] && cyc < 20000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            #1;
        end
        if (av_rdata[0]) chk("busy_bound", av_rdata, 32'd0);
    endtask

    task automatic run_cfg(input int w, input int h, input logic [15:0] src,
                           input logic [15:0] dst, input string tag);
        int          cyc, tiles, nbad;
        logic [31:0] v;
        logic [15:0] erd [$];
        logic [47:0] ewr [$];
        wr(4'd2, w); wr(4'd3, h); wr(4'd4, 32'(src)); wr(4'd5, 32'(dst));
        rd_q.delete(); wr_q.delete();
        n_starts = 0; d_sum = 0;
        go_and_wait(cyc);
        tiles = ((h - 1) / 2) * ((w - 1) / 2);
        for (int r = 0; r + 2 < h; r += 2)
            for (int c = 0; c + 2 < w; c += 2) begin
                for (int k = 0; k < 9; k++)
                    erd.push_back(16'(int'(src) + (r + k / 3) * w + c + k % 3));
                for (int j = 0; j < 4; j++)
                    ewr.push_back({16'(int'(dst) + (r + j / 2) * (w - 1) + c + j % 2),
                        mem[16'(int'(src) + (r + j / 2) * w + c + j % 2)] + 32'h100 * (j + 1)});
            end
        chk({tag, "_cycles"}, cyc, 1 + 16 * tiles + d_sum);
        chk({tag, "_starts"}, n_starts, tiles);
        chk({tag, "_nrd"}, rd_q.size(), erd.size());
        chk({tag, "_nwr"}, wr_q.size(), ewr.size());
        nbad = 0;
        for (int i = 0; i < erd.size() && i < rd_q.size(); i++)
            if (rd_q[i] !== erd[i]) begin
                nbad++;
                $display("  %s read %0d at 0x%0h, model 0x%0h", tag, i, rd_q[i], erd[i]);
            end
        chk({tag, "_rd_bad"}, nbad, 0);
        nbad = 0;
        for (int i = 0; i < ewr.size() && i < wr_q.size(); i++)
            if (wr_q[i] !== ewr[i]) begin
                nbad++;
                $display("  %s write %0d got 0x%0h, model 0x%0h", tag, i, wr_q[i], ewr[i]);
            end
        chk({tag, "_wr_bad"}, nbad, 0);
        rd(4'd1, v); chk({tag, "_status"}, v, 32'h2);
        rd(4'd6, v); chk({tag, "_tiles"}, v, tiles);
    endtask

    initial begin
        logic [31:0] v;
        int          cyc, nr, bound;
        rst_n = 1'b0; av_addr = '0; av_rd = 1'b0; av_wr = 1'b0; av_wd = '0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        repeat (3) @(negedge clk);
        chk("rst_strobes", {29'd0, img_rd, res_wr, core_start}, 32'd0);
        chk("rst_core_in4", cin[4], 32'd0);
        rst_n = 1'b1;
        rd(4'd1, v); chk("rst_status", v, 32'd0);
        rd(4'd6, v); chk("rst_tiles", v, 32'd0);
        rd(4'd2, v); chk("rst_img_w", v, 32'd0);

        for (int i = 0; i < 9; i++) mem[16'h10 + i] = 32'(i + 1);
        d_fixed = 3;
        run_cfg(3, 3, 16'h10, 16'h40, "t3x3");
        for (int k = 0; k < 9; k++) chk("t3x3_core_in", last_cin[k], 32'(k + 1));
        d_fixed = 0;
        run_cfg(5, 5, 16'h0, 16'h100, "t5x5");
        for (int n = 0; n < 4; n++)
            run_cfg(2 * int'($urandom_range(1, 4)) + 1, 2 * int'($urandom_range(1, 4)) + 1,
                    16'($urandom), 16'($urandom), "rand");
        run_cfg(7, 3, 16'hFFF0, 16'hFFFE, "wrap");

        rd(4'd7, v); chk("addr7_zero", v, 32'd0);
        rd(4'd0, v); chk("ctrl_zero", v, 32'd0);
        wr(4'd1, 32'h2); rd(4'd1, v); chk("w1c_done", v, 32'd0);

        for (int n = 0; n < 2; n++) begin
            wr(4'd2, n == 0 ? 32'd4 : 32'd5);
            wr(4'd3, n == 0 ? 32'd5 : 32'd1);
            rd_q.delete();
            wr(4'd0, 32'd1);
            repeat (3) @(negedge clk);
            rd(4'd1, v); chk("cfg_err", v, 32'h4);
            chk("cfg_no_rd", rd_q.size(), 0);
            wr(4'd1, 32'h4); rd(4'd1, v); chk("cfg_w1c", v, 32'd0);
        end

        wr(4'd2, 32'd3); wr(4'd3, 32'd3);
        rd_q.delete(); wr_q.delete(); n_starts = 0; hang_from = 1;
        go_and_wait(cyc);
        chk("to_cycles", cyc, 1036);
        rd(4'd1, v); chk("to_status", v, 32'h8);
        chk("to_no_wr", wr_q.size(), 0);
        hang_from = 1000;
        wr(4'd1, 32'h1E);

        wr(4'd2, 32'd5); wr(4'd3, 32'd5);
        wr(4'd0, 32'h3);
        repeat (4) @(negedge clk);
        rd(4'd1, v); chk("goabort_idle", v, 32'd0);

        rd_q.delete(); wr_q.delete(); n_starts = 0; hang_from = 2;
        wr(4'd0, 32'd1);
        bound = 0;
        while (n_starts < 2 && bound < 500) begin
            @(negedge clk);
            bound++;
        end
        chk("ab_reach_tile2", n_starts, 2);
        repeat (3) @(negedge clk);
        wr(4'd0, 32'd1);
        wr(4'd2, 32'd7);
        @(negedge clk);
        av_addr = 4'd0; av_wd = 32'h2; av_wr = 1'b1;
        @(negedge clk);
        av_wr = 1'b0; av_addr = 4'd1;
        #1 chk("ab_status", av_rdata, 32'h10);
        nr = rd_q.size();
        repeat (5) @(negedge clk);
        chk("ab_no_more_rd", rd_q.size(), nr);
        chk("ab_nrd", nr, 18);
        chk("ab_nwr", wr_q.size(), 4);
        rd(4'd6, v); chk("ab_tiles", v, 32'd1);
        rd(4'd2, v); chk("ab_img_w_kept", v, 32'd5);
        hang_from = 1000;
        wr(4'd1, 32'h1E);

        rd_q.delete();
        wr(4'd0, 32'd1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rmid_strobes", {29'd0, img_rd, res_wr, core_start}, 32'd0);
        chk("rmid_addr", 32'(img_addr), 32'd0);
        chk("rmid_core_in0", cin[0], 32'd0);
        av_addr = 4'd1;
        #1 chk("rmid_status", av_rdata, 32'd0);
        av_addr = 4'd6;
        #1 chk("rmid_tiles", av_rdata, 32'd0);
        rst_n = 1'b1;
        nr = rd_q.size();
        repeat (5) @(negedge clk);
        chk("rmid_no_rd", rd_q.size(), nr);
        chk("no_rd_wr_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
